// File: rtl/victim_writeback_buffer_if.sv
// -----------------------------------------------------------------------------
// victim_writeback_buffer_if
//
// Bundles the two LC-3b style memory handshakes that meet at the victim
// writeback buffer:
//   - victim-cache side: the evicted-line write port (vc_wb_*) and the line
//     read port (vc_read / vc_address / vc_rdata / vc_resp)
//   - physical-memory side: pmem_read / pmem_write / pmem_address /
//     pmem_wdata / pmem_rdata / pmem_resp
// Every request is held high until the matching one-cycle resp.
//
// Modports:
//   slave  - the buffer itself
//   master - the surroundings (victim cache plus physical memory)
// -----------------------------------------------------------------------------
interface victim_writeback_buffer_if;
    logic         vc_wb_write;
    logic [15:0]  vc_wb_address;
    logic [127:0] vc_wb_wdata;
    logic         vc_wb_resp;

    logic         vc_read;
    logic [15:0]  vc_address;
    logic [127:0] vc_rdata;
    logic         vc_resp;

    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  vc_wb_write, vc_wb_address, vc_wb_wdata,
        input  vc_read, vc_address,
        input  pmem_rdata, pmem_resp,
        output vc_wb_resp, vc_rdata, vc_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output vc_wb_write, vc_wb_address, vc_wb_wdata,
        output vc_read, vc_address,
        output pmem_rdata, pmem_resp,
        input  vc_wb_resp, vc_rdata, vc_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/victim_writeback_buffer.sv
// -----------------------------------------------------------------------------
// victim_writeback_buffer
//
// Queues dirty 128-bit lines evicted by the victim cache and drains them to
// physical memory in the background. Victim-cache miss reads pass through to
// pmem, except when the line is still buffered: then the youngest buffered
// copy is returned without touching pmem.
//
// Parameters:
//   DEPTH  number of line entries (power of two, 2..8)
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   bus       victim_writeback_buffer_if.slave (vc_wb_*, vc_read/vc_*, pmem_*)
//   wb_empty  high when the buffer holds no valid entries (registered)
//
// Optional build macro:
//   VICTIM_WB_COALESCE_EN  when defined, an enqueue whose tag matches a valid
//                          entry that is not currently being drained overwrites
//                          that entry in place instead of allocating a new one.
// -----------------------------------------------------------------------------
module victim_writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    victim_writeback_buffer_if.slave  bus,
    output logic                      wb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_HIT,
        RD_MEM,
        DRAIN
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [DEPTH-1:0] valid_reg;
    logic            wb_resp_reg;
    logic            wb_empty_reg;
    logic [127:0]    hit_data_reg;

    // Line storage: tag and data arrays without reset; validity lives in
    // valid_reg so the arrays map cleanly onto plain storage.
    logic [11:0]     tag_mem  [DEPTH];
    logic [127:0]    data_mem [DEPTH];

    logic            full;
    logic            empty;
    logic            in_flight;
    logic            pop;
    logic            push;
    logic            accept;
    logic            coalesce;
    logic            latch_hit;

    logic [DEPTH-1:0] rd_match;
    logic [PW:0]      rd_pick;
    logic             rd_hit;
    logic [PW-1:0]    hit_idx;

    logic             cl_hit;
    logic [PW-1:0]    cl_idx;

    // Low address bits select a word inside the line and are irrelevant here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.vc_wb_address[3:0], bus.vc_address[3:0]};

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign in_flight = (state_reg == DRAIN);

    // Walks the entries from oldest (head) to youngest; the last match wins,
    // so the result is the match nearest to the tail. Entries outside the
    // head..tail window are never valid, so ordering by offset from head is
    // the true age order. Returns {found, index}.
    function automatic logic [PW:0] pick_youngest(input logic [DEPTH-1:0] m,
                                                  input logic [PW-1:0]    h);
        logic [PW:0]   r;
        logic [PW-1:0] idx;
        r   = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = h + PW'(k);
            if (m[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_match
        assign rd_match[gi] = valid_reg[gi] &&
                              (tag_mem[gi] == bus.vc_address[15:4]);
    end

    assign rd_pick = pick_youngest(rd_match, head_reg);
    assign rd_hit  = rd_pick[PW];
    assign hit_idx = rd_pick[PW-1:0];

`ifdef VICTIM_WB_COALESCE_EN
    logic [DEPTH-1:0] cl_match;
    logic [PW:0]      cl_pick;

    // The head entry is excluded while it is being written to pmem so the
    // data on pmem_wdata never changes under an open request.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cl_match
        assign cl_match[gi] = valid_reg[gi] &&
                              (tag_mem[gi] == bus.vc_wb_address[15:4]) &&
                              !(in_flight && (head_reg == PW'(gi)));
    end

    assign cl_pick = pick_youngest(cl_match, head_reg);
    assign cl_hit  = cl_pick[PW];
    assign cl_idx  = cl_pick[PW-1:0];
`else
    assign cl_hit  = 1'b0;
    assign cl_idx  = '0;
`endif

    // Write acceptance is independent of the FSM. wb_resp_reg blocks a second
    // acceptance during the resp cycle, when the requester still holds write.
    assign accept   = bus.vc_wb_write && !wb_resp_reg && (cl_hit || !full);
    assign coalesce = accept && cl_hit;
    assign push     = accept && !cl_hit;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FSM next state and outputs.
    always_comb begin
        state_next       = state_reg;
        pop              = 1'b0;
        latch_hit        = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.vc_resp      = 1'b0;
        bus.vc_rdata     = '0;

        case (state_reg)
            IDLE: begin
                // A blocked enqueue outranks a read so a full buffer cannot
                // be starved by a stream of reads.
                if (full && bus.vc_wb_write) begin
                    state_next = DRAIN;
                end else if (bus.vc_read) begin
                    if (rd_hit) begin
                        state_next = RD_HIT;
                        latch_hit  = 1'b1;
                    end else begin
                        state_next = RD_MEM;
                    end
                end else if (!empty) begin
                    state_next = DRAIN;
                end
            end

            RD_HIT: begin
                bus.vc_resp  = 1'b1;
                bus.vc_rdata = hit_data_reg;
                state_next   = IDLE;
            end

            RD_MEM: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {bus.vc_address[15:4], 4'h0};
                if (bus.pmem_resp) begin
                    bus.vc_resp  = 1'b1;
                    bus.vc_rdata = bus.pmem_rdata;
                    state_next   = IDLE;
                end
            end

            DRAIN: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_mem[head_reg], 4'h0};
                bus.pmem_wdata   = data_mem[head_reg];
                if (bus.pmem_resp) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= '0;
            wb_resp_reg  <= 1'b0;
            wb_empty_reg <= 1'b1;
            hit_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            wb_empty_reg <= (count_next == '0);
            wb_resp_reg  <= accept;
            if (latch_hit) begin
                hit_data_reg <= data_mem[hit_idx];
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            // Push and pop never target the same slot: a pop needs count>0
            // and a push needs count<DEPTH, so head != tail whenever both fire.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b1;
                end else if (pop && (head_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Line storage writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push) begin
                tag_mem[tail_reg]  <= bus.vc_wb_address[15:4];
                data_mem[tail_reg] <= bus.vc_wb_wdata;
            end else if (coalesce) begin
                data_mem[cl_idx] <= bus.vc_wb_wdata;
            end
        end
    end

    assign bus.vc_wb_resp = wb_resp_reg;
    assign wb_empty       = wb_empty_reg;

endmodule

// File: doc/victim_writeback_buffer.md
Name: victim_writeback_buffer

Overview:
- Sits directly downstream of the victim cache, between it and physical memory.
- Evictions of dirty 128-bit lines from the victim cache are queued here and drained to pmem in the background.
- Victim-cache miss reads pass through to pmem; lines still held in the buffer are forwarded without touching pmem.
- Uses the LC-3b memory handshake: request is held high until a one-cycle resp.

Parameters:
DEPTH, 4, number of line entries; power of two, 2..8.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
vc_wb_write  in  1  enqueue request for a dirty evicted line; held until vc_wb_resp
vc_wb_address  in  16  evicted line address; [3:0] ignored
vc_wb_wdata  in  128  evicted line data
vc_wb_resp  out  1  one-cycle pulse: line accepted
vc_read  in  1  line read request from victim cache; held until vc_resp
vc_address  in  16  read line address; [3:0] ignored
vc_rdata  out  128  read data; valid in the vc_resp cycle
vc_resp  out  1  one-cycle pulse: read complete
pmem_read  out  1  pmem read request
pmem_write  out  1  pmem write request
pmem_address  out  16  {line tag[15:4], 4'b0000}
pmem_wdata  out  128  line data for writes
pmem_rdata  in  128  pmem read data
pmem_resp  in  1  pmem one-cycle completion
wb_empty  out  1  high when no valid entries

Behaviour:
- Storage: DEPTH entries, each holding valid, tag[11:0] and data[127:0]. Organised as a circular FIFO with head/tail pointers of log2(DEPTH) bits (wrap-around) and a count of log2(DEPTH)+1 bits.
- Reset: clears all valid bits, pointers, count and FSM state (to IDLE). All outputs are 0 except wb_empty=1. Reset mid-transaction abandons it; no resp is emitted.
- FSM states:
  - IDLE. Priority order:
    - (a) if full and vc_wb_write is pending, go to DRAIN;
    - (b) else if vc_read, go to RD_HIT when any entry tag matches, otherwise RD_MEM;
    - (c) else if not empty, go to DRAIN.
  - RD_HIT: vc_rdata = youngest matching entry; vc_resp=1 for one cycle; return to IDLE. Hit latency is 1 cycle after the request is seen in IDLE.
  - RD_MEM: pmem_read=1 with pmem_address={vc_address[15:4],4'h0}. On pmem_resp, vc_rdata=pmem_rdata and vc_resp=1 in the same cycle; return to IDLE.
  - DRAIN: pmem_write=1, with pmem_address and pmem_wdata taken from the head entry. On pmem_resp, clear head.valid, advance head, decrement count, return to IDLE.
- A drain, once started, is never preempted by a read.
- Write acceptance runs independently of the FSM:
  - While vc_wb_write is high and a slot is available, the line is allocated at the tail.
  - vc_wb_resp pulses on the next edge; tail and count increment.
  - When full, vc_wb_resp stays low until a drain frees an entry. Acceptance occurs in the cycle after the pop.
- Simultaneous pop and push in the same cycle: count is unchanged and both pointers advance.
- The head entry is frozen while DRAIN is active. An enqueue to the same line allocates a new entry, so the in-flight data is never modified.
- Read forwarding selects the youngest match (nearest to tail). Reads never return stale pmem data for a buffered line.
- wb_empty = (count==0), registered from state.
- pmem_read and pmem_write are never high together.

Optional Feature:
- Macro: VICTIM_WB_COALESCE_EN.
- Defined: an enqueue whose tag matches a valid, non-in-flight entry overwrites that entry's data in place. No allocation, count unchanged, vc_wb_resp one cycle later. Acceptance succeeds even when full if it coalesces.
- Undefined: every enqueue allocates a new entry, and duplicate tags may coexist.

Test Plan:
- Reset then enqueue line 0x1230 data A: vc_wb_resp on the next cycle, wb_empty falls. Idle bench: pmem_write to 0x1230 with A; pmem_resp pops the entry and wb_empty=1.
- Fill DEPTH=4 lines while holding pmem_resp low, then enqueue a 5th: vc_wb_resp stays low until the first drain pmem_resp, and is accepted the cycle after. Drain order equals enqueue order, including across pointer wrap.
- Enqueue 0x4560 data B, then read 0x4567 before it drains: vc_resp after 1 cycle with B, no pmem_read. A read of 0x7890 gives pmem_read to 0x7890, and vc_rdata equals pmem_rdata on pmem_resp.
- While draining 0x1230 (A), enqueue 0x1230 data C: a new entry is allocated, pmem writes A then C. A read of 0x1230 mid-sequence returns C.
- Coalesce (macro defined): enqueue 0x2220 data D then 0x2220 data E with no drain: count=1 and the drain writes E only. Same stimulus with the macro undefined: count=2, and pmem writes D then E.
- Assert reset during RD_MEM and DRAIN: no vc_resp, pmem requests drop the next cycle, all entries invalid, wb_empty=1.
